// File: rtl/mig_app_traffic_gen.sv
// Write/read-back traffic generator for the MIG 7-series native app interface.
// Writes a seed-derived pattern, reads it back, compares every returned beat
// and keeps sticky error status. Full app_rdy/app_wdf_rdy back-pressure.
module mig_app_traffic_gen #(
  parameter int ADDR_WIDTH  = 29,
  parameter int DATA_WIDTH  = 256,
  parameter int ADDR_STRIDE = 8,
  parameter int BEAT_WIDTH  = 16,
  parameter int ERR_WIDTH   = 16
) (
  input  logic                    ui_clk,
  input  logic                    sys_rst,
  input  logic                    init_calib_complete,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [BEAT_WIDTH-1:0]   num_beats,
  input  logic [31:0]             seed,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    tg_compare_error,
  output logic [ERR_WIDTH-1:0]    error_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam int WORDS = DATA_WIDTH / 32;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CAL, S_WRITE, S_READ, S_DRAIN, S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [BEAT_WIDTH-1:0]   num_q, num_d;
  logic [31:0]             seed_q, seed_d;
  logic                    wr_phase_q, wr_phase_d;   // run includes a write pass
  logic                    rd_phase_q, rd_phase_d;   // run includes a read/check pass
  logic [BEAT_WIDTH-1:0]   beat_q, beat_d;           // index of the beat being issued
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             word_q, word_d;           // write pattern word for current beat
  logic [2:0]              cmd_q, cmd_d;
  logic                    en_q, en_d;
  logic                    wren_q, wren_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cmp_err_q, cmp_err_d;
  logic [ERR_WIDTH-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
  logic                    rd_active_q, rd_active_d; // returns are being checked
  logic [BEAT_WIDTH-1:0]   ret_cnt_q, ret_cnt_d;
  logic [31:0]             exp_word_q, exp_word_d;   // expected word of next return
  logic [ADDR_WIDTH-1:0]   exp_addr_q, exp_addr_d;   // address of next return

  logic                    cmd_ok;     // command of current write beat accepted (now or earlier)
  logic                    dat_ok;     // data of current write beat accepted (now or earlier)
  logic                    last_beat;
  logic [WORDS-1:0]        word_match;

  assign cmd_ok    = !en_q || app_rdy;
  assign dat_ok    = !wren_q || app_wdf_rdy;
  assign last_beat = (beat_q == num_q - BEAT_WIDTH'(1));

  // Replicate the pattern word across the bus and compare each 32-bit lane
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
      assign app_wdf_data[gi*32 +: 32] = word_q;
      assign word_match[gi] = (app_rd_data[gi*32 +: 32] == exp_word_q);
    end
  endgenerate

  // Next-state logic: run sequencing plus the independent return checker
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    seed_d      = seed_q;
    wr_phase_d  = wr_phase_q;
    rd_phase_d  = rd_phase_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    word_d      = word_q;
    cmd_d       = cmd_q;
    en_d        = en_q;
    wren_d      = wren_q;
    busy_d      = busy_q;
    done_d      = done_q;
    cmp_err_d   = cmp_err_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    rd_active_d = rd_active_q;
    ret_cnt_d   = ret_cnt_q;
    exp_word_d  = exp_word_q;
    exp_addr_d  = exp_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          num_d       = num_beats;
          seed_d      = seed;
          wr_phase_d  = (mode != 2'd2);
          rd_phase_d  = (mode != 2'd1);
          done_d      = 1'b0;
          cmp_err_d   = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          busy_d      = 1'b1;
          ret_cnt_d   = '0;
          exp_word_d  = seed;
          exp_addr_d  = base_addr;
          state_d     = S_WAIT_CAL;
        end
      end
      S_WAIT_CAL: begin
        if (init_calib_complete) begin
          beat_d = '0;
          addr_d = base_q;
          if (num_q == '0) begin
            state_d = S_FINISH;
          end else if (wr_phase_q) begin
            en_d    = 1'b1;
            wren_d  = 1'b1;
            cmd_d   = CMD_WR;
            word_d  = seed_q;
            state_d = S_WRITE;
          end else begin
            en_d        = 1'b1;
            cmd_d       = CMD_RD;
            rd_active_d = 1'b1;
            state_d     = S_READ;
          end
        end
      end
      S_WRITE: begin
        // Each half of the beat drops as soon as its own handshake completes
        en_d   = en_q && !app_rdy;
        wren_d = wren_q && !app_wdf_rdy;
        if (cmd_ok && dat_ok) begin
          if (!last_beat) begin
            en_d   = 1'b1;
            wren_d = 1'b1;
            addr_d = addr_q + STRIDE;
            word_d = word_q + 32'd1;
            beat_d = beat_q + BEAT_WIDTH'(1);
          end else if (rd_phase_q) begin
            en_d        = 1'b1;
            cmd_d       = CMD_RD;
            addr_d      = base_q;
            beat_d      = '0;
            rd_active_d = 1'b1;
            state_d     = S_READ;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_READ: begin
        if (app_rdy) begin
          if (last_beat) begin
            en_d    = 1'b0;
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + STRIDE;
            beat_d = beat_q + BEAT_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (ret_cnt_q == num_q) state_d = S_FINISH;
      end
      S_FINISH: begin
        busy_d      = 1'b0;
        done_d      = 1'b1;
        rd_active_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // In-order return checking, independent of the command side
    if (rd_active_q && app_rd_data_valid && (ret_cnt_q != num_q)) begin
      ret_cnt_d  = ret_cnt_q + BEAT_WIDTH'(1);
      exp_word_d = exp_word_q + 32'd1;
      exp_addr_d = exp_addr_q + STRIDE;
      if (!(&word_match)) begin
        cmp_err_d = 1'b1;
        if (err_cnt_q == '0) first_err_d = exp_addr_q;
        if (err_cnt_q != {ERR_WIDTH{1'b1}}) err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      seed_q      <= '0;
      wr_phase_q  <= 1'b0;
      rd_phase_q  <= 1'b0;
      beat_q      <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      cmd_q       <= '0;
      en_q        <= 1'b0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      rd_active_q <= 1'b0;
      ret_cnt_q   <= '0;
      exp_word_q  <= '0;
      exp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      seed_q      <= seed_d;
      wr_phase_q  <= wr_phase_d;
      rd_phase_q  <= rd_phase_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      cmd_q       <= cmd_d;
      en_q        <= en_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmp_err_q   <= cmp_err_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      rd_active_q <= rd_active_d;
      ret_cnt_q   <= ret_cnt_d;
      exp_word_q  <= exp_word_d;
      exp_addr_q  <= exp_addr_d;
    end
  end

  assign app_addr         = addr_q;
  assign app_cmd          = cmd_q;
  assign app_en           = en_q;
  assign app_wdf_wren     = wren_q;
  assign app_wdf_end      = wren_q;
  assign app_wdf_mask     = '0;
  assign busy             = busy_q;
  assign done             = done_q;
  assign tg_compare_error = cmp_err_q;
  assign error_count      = err_cnt_q;
  assign first_err_addr   = first_err_q;

endmodule

// File: tb/tb_mig_app_traffic_gen.sv
// Bench for mig_app_traffic_gen: MIG app-port memory model with back-pressure
// and in-order read latency, table of directed runs, random runs, and
// hand-written sequences for zero-length runs and reset during drain.
module tb_mig_app_traffic_gen;
  localparam int AW = 29;
  localparam int DW = 256;
  localparam int BW = 16;
  localparam int EW = 16;
  localparam int STRIDE = 8;

  logic          ui_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          init_calib_complete = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] base_addr = '0;
  logic [BW-1:0] num_beats = '0;
  logic [31:0]   seed = '0;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy = 1'b0;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic          app_wdf_rdy = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          busy, done, tg_compare_error;
  logic [EW-1:0] error_count;
  logic [AW-1:0] first_err_addr;

  mig_app_traffic_gen dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .start(start), .mode(mode), .base_addr(base_addr), .num_beats(num_beats), .seed(seed),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy), .done(done), .tg_compare_error(tg_compare_error),
    .error_count(error_count), .first_err_addr(first_err_addr)
  );

  always #5 ui_clk = ~ui_clk;

  // ---------------- memory model state ----------------
  typedef struct { logic [DW-1:0] data; int due; } ret_t;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  logic [AW-1:0] wlog_addr[$];
  logic [DW-1:0] wlog_data[$];
  int            wlog_cyc[$];
  logic [AW-1:0] rlog_addr[$];
  ret_t          pend[$];
  ret_t          mon_ret, drv_ret;
  int            cyc = 0, pol = 0, stall_left = 0, stall_at = 3;
  int            lat_min = 2, lat_max = 6, last_due = 0, en_cycles = 0, mon_due;
  bit            garble = 1'b0;
  logic [AW-1:0] mw_addr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pattern and address of beat k, straight from the definition
  function automatic logic [DW-1:0] pat(input logic [31:0] sd, input int k);
    logic [31:0] w;
    w = sd + 32'(k);
    return {(DW/32){w}};
  endfunction

  function automatic logic [AW-1:0] adr(input logic [AW-1:0] b, input int k);
    return AW'(longint'(b) + longint'(k) * STRIDE);
  endfunction

  // Handshake monitor: values at the falling edge are those seen at the next rising edge
  always @(negedge ui_clk) begin
    if (sys_rst) begin
      if (app_en) en_cycles++;
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b000) begin
          wq_addr.push_back(app_addr);
          wlog_addr.push_back(app_addr);
          wlog_cyc.push_back(cyc);
        end else begin
          rlog_addr.push_back(app_addr);
          mon_due = cyc + int'($urandom_range(lat_max, lat_min));
          if (mon_due <= last_due) mon_due = last_due + 1;
          last_due = mon_due;
          mon_ret.data = mem.exists(app_addr) ? mem[app_addr] : '0;
          mon_ret.due = mon_due;
          pend.push_back(mon_ret);
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        wq_data.push_back(app_wdf_data);
        wlog_data.push_back(app_wdf_data);
      end
      while (wq_addr.size() > 0 && wq_data.size() > 0) begin
        mw_addr = wq_addr.pop_front();
        mem[mw_addr] = wq_data.pop_front();
      end
    end
  end

  // Ready and read-return driver, one step after each rising edge
  initial begin
    forever begin
      @(posedge ui_clk);
      #1;
      cyc++;
      case (pol)
        0: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
        1: begin
          app_rdy     = ($urandom_range(3, 0) != 0);
          app_wdf_rdy = ($urandom_range(3, 0) != 0);
        end
        default: begin
          app_rdy = 1'b1;
          if (app_wdf_wren && wlog_data.size() >= stall_at && stall_left > 0) begin
            app_wdf_rdy = 1'b0;
            stall_left--;
          end else begin
            app_wdf_rdy = 1'b1;
          end
        end
      endcase
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        drv_ret = pend.pop_front();
        app_rd_data = garble ? ~drv_ret.data : drv_ret.data;
        app_rd_data_valid = 1'b1;
      end else begin
        app_rd_data = {(DW/32){$urandom()}};
        app_rd_data_valid = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ui_clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete(); rlog_addr.delete();
    en_cycles = 0;
  endtask

  task automatic pulse_start(input logic [1:0] md, input logic [AW-1:0] b, input int nb,
                             input logic [31:0] sd);
    @(posedge ui_clk); #2;
    mode = md; base_addr = b; num_beats = BW'(nb); seed = sd; start = 1'b1;
    @(posedge ui_clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_pend_empty(input string tag);
    int w;
    w = 0;
    while (pend.size() > 0 && w < 200) begin tick(1); w++; end
    chk({tag, "/returns_drained"}, DW'(pend.size()), '0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/app_en"}, DW'(app_en), '0);
    chk({tag, "/app_wdf_wren"}, DW'(app_wdf_wren), '0);
    chk({tag, "/app_wdf_end"}, DW'(app_wdf_end), '0);
    chk({tag, "/busy"}, DW'(busy), '0);
    chk({tag, "/done"}, DW'(done), '0);
    chk({tag, "/tg_compare_error"}, DW'(tg_compare_error), '0);
    chk({tag, "/error_count"}, DW'(error_count), '0);
    chk({tag, "/first_err_addr"}, DW'(first_err_addr), '0);
    chk({tag, "/app_addr"}, DW'(app_addr), '0);
    chk({tag, "/app_cmd"}, DW'(app_cmd), '0);
    chk({tag, "/app_wdf_data"}, app_wdf_data, '0);
    chk({tag, "/app_wdf_mask"}, DW'(app_wdf_mask), '0);
  endtask

  // One complete run, checked against a model of the memory contents
  task automatic run(input string tag, input logic [1:0] md, input logic [AW-1:0] b,
                     input int nb, input logic [31:0] sd, input int pl,
                     input bit use_tbl, input int t_err, input logic [AW-1:0] t_first);
    logic [DW-1:0] shadow [logic [AW-1:0]];
    logic [DW-1:0] cur;
    logic [AW-1:0] a;
    int e_err, n_wr, n_rd, w;
    logic [AW-1:0] e_first;
    bit wr, rd;
    shadow = mem;
    wr = (md != 2'd2);
    rd = (md != 2'd1);
    n_wr = wr ? nb : 0;
    n_rd = rd ? nb : 0;
    e_err = 0;
    e_first = '0;
    if (wr) for (int k = 0; k < nb; k++) shadow[adr(b, k)] = pat(sd, k);
    if (rd) begin
      for (int k = 0; k < nb; k++) begin
        a = adr(b, k);
        cur = shadow.exists(a) ? shadow[a] : '0;
        if (cur !== pat(sd, k)) begin
          if (e_err == 0) e_first = a;
          e_err++;
        end
      end
    end
    if (use_tbl) begin
      e_err = t_err;
      e_first = t_first;
    end
    clear_logs();
    pol = pl;
    stall_left = 3;
    pulse_start(md, b, nb, sd);
    chk({tag, "/busy_after_start"}, DW'(busy), DW'(1));
    chk({tag, "/done_cleared"}, DW'(done), '0);
    w = 0;
    while (!done && w < 3000) begin tick(1); w++; end
    chk({tag, "/done"}, DW'(done), DW'(1));
    chk({tag, "/busy_end"}, DW'(busy), '0);
    chk({tag, "/write_cmds"}, DW'(wlog_addr.size()), DW'(n_wr));
    chk({tag, "/write_data"}, DW'(wlog_data.size()), DW'(n_wr));
    chk({tag, "/read_cmds"}, DW'(rlog_addr.size()), DW'(n_rd));
    for (int k = 0; k < n_wr && k < wlog_addr.size() && k < wlog_data.size(); k++) begin
      chk($sformatf("%s/wr_addr[%0d]", tag, k), DW'(wlog_addr[k]), DW'(adr(b, k)));
      chk($sformatf("%s/wr_data[%0d]", tag, k), wlog_data[k], pat(sd, k));
    end
    for (int k = 0; k < n_rd && k < rlog_addr.size(); k++)
      chk($sformatf("%s/rd_addr[%0d]", tag, k), DW'(rlog_addr[k]), DW'(adr(b, k)));
    chk({tag, "/error_count"}, DW'(error_count), DW'(e_err));
    chk({tag, "/tg_compare_error"}, DW'(tg_compare_error), DW'(e_err != 0));
    chk({tag, "/first_err_addr"}, DW'(first_err_addr), DW'(e_first));
    $display("run %s mode=%0d base=%0h beats=%0d seed=%0h errors=%0d", tag, md, b, nb, sd,
             error_count);
    wait_pend_empty(tag);
  endtask

  typedef struct {
    string tag; logic [1:0] md; logic [AW-1:0] b; int nb; logic [31:0] sd; int pl;
    int corrupt; int x_err; logic [AW-1:0] x_first;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input string tag, input logic [1:0] md, input logic [AW-1:0] b,
                         input int nb, input logic [31:0] sd, input int pl, input int corrupt,
                         input int x_err, input logic [AW-1:0] x_first);
    vec_t v;
    v.tag = tag; v.md = md; v.b = b; v.nb = nb; v.sd = sd; v.pl = pl;
    v.corrupt = corrupt; v.x_err = x_err; v.x_first = x_first;
    tbl.push_back(v);
  endtask

  initial begin
    int w;
    logic [DW-1:0] pv;
    add_vec("m0_seq20",     2'd0, 29'h0,        20, 32'h0,        0, -1, 0, 29'h0);
    add_vec("m0_wdf_stall", 2'd0, 29'h40,        8, 32'h5,        2, -1, 0, 29'h0);
    add_vec("m2_corrupt5",  2'd2, 29'h100,       8, 32'h1234,     1,  5, 1, 29'h128);
    add_vec("m0_wrap",      2'd0, 29'h1FFFFFF0,  4, 32'hABCD0000, 0, -1, 0, 29'h0);
    add_vec("m3_rand_rdy",  2'd3, 29'h2000,     12, 32'hFFFFFFF8, 1, -1, 0, 29'h0);

    // Reset state
    tick(3);
    chk_reset("reset");
    sys_rst = 1'b1;
    init_calib_complete = 1'b1;
    tick(2);

    // Directed table
    foreach (tbl[i]) begin
      if (tbl[i].corrupt >= 0) begin
        for (int k = 0; k < tbl[i].nb; k++) begin
          pv = pat(tbl[i].sd, k);
          if (k == tbl[i].corrupt) pv[0] = ~pv[0];
          mem[adr(tbl[i].b, k)] = pv;
        end
      end
      run(tbl[i].tag, tbl[i].md, tbl[i].b, tbl[i].nb, tbl[i].sd, tbl[i].pl, 1'b1,
          tbl[i].x_err, tbl[i].x_first);
      if (i == 0 && wlog_cyc.size() == 20)
        chk("m0_seq20/write_span_cycles", DW'(wlog_cyc[19] - wlog_cyc[0]), DW'(19));
      if (i == 3 && rlog_addr.size() == 4) begin
        chk("m0_wrap/rd_addr2", DW'(rlog_addr[2]), DW'(29'h0));
        chk("m0_wrap/rd_addr3", DW'(rlog_addr[3]), DW'(29'h8));
      end
    end

    // Random runs against the memory model
    for (int r = 0; r < 8; r++) begin
      run($sformatf("rand%0d", r), 2'($urandom_range(3, 0)), AW'($urandom()),
          int'($urandom_range(24, 1)), $urandom(), 1, 1'b0, 0, '0);
    end

    // Zero-length run; a second start during the run must be ignored
    init_calib_complete = 1'b0;
    clear_logs();
    pol = 0;
    pulse_start(2'd0, 29'h500, 0, 32'h9);
    tick(3);
    chk("zero/busy_wait_cal", DW'(busy), DW'(1));
    chk("zero/done_wait_cal", DW'(done), '0);
    pulse_start(2'd1, 29'h600, 5, 32'h77);
    init_calib_complete = 1'b1;
    w = 0;
    while (!done && w < 50) begin tick(1); w++; end
    chk("zero/done", DW'(done), DW'(1));
    chk("zero/no_app_en", DW'(en_cycles), '0);
    tick(5);
    chk("zero/done_level", DW'(done), DW'(1));
    chk("zero/still_no_app_en", DW'(en_cycles), '0);
    $display("run zero beats done=%0d app_en_cycles=%0d", done, en_cycles);

    // Reset in DRAIN with three reads outstanding; late returns are garbled
    lat_min = 8; lat_max = 8; pol = 0;
    clear_logs();
    pulse_start(2'd0, 29'h3000, 10, 32'd77);
    w = 0;
    while (!(rlog_addr.size() == 10 && pend.size() == 3) && w < 500) begin
      @(posedge ui_clk); #1; w++;
    end
    chk("rst_drain/reached_drain", DW'(pend.size()), DW'(3));
    #1;
    sys_rst = 1'b0;
    garble = 1'b1;
    #2;
    chk_reset("rst_drain");
    tick(2);
    sys_rst = 1'b1;
    wait_pend_empty("rst_drain");
    tick(2);
    chk("rst_drain/late_err_count", DW'(error_count), '0);
    chk("rst_drain/late_cmp_error", DW'(tg_compare_error), '0);
    chk("rst_drain/idle_busy", DW'(busy), '0);
    $display("run reset_in_drain error_count=%0d", error_count);
    garble = 1'b0;
    lat_min = 2; lat_max = 6;
    run("post_reset", 2'd0, 29'h3000, 10, 32'd78, 1, 1'b0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
